adder_share_ctrl: RTL

ADDER_SHARE_CTRL -- requirements
Module: adder_share_ctrl

---
 rtl/adder_share_pkg.sv | 19 +
 rtl/adder_share_if.sv | 36 +++
 rtl/adder_share_ctrl_arb.sv | 31 +++
 rtl/adder_share_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and constants for the time-shared adder controller.
// The arbitration mode is selected in rr_arb2 by the ADDER_SHARE_RR_EN macro.
package adder_share_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int NUM_REQ     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/adder_share_if.sv
// Request/response bundle between two requesters plus one consumer and the
// shared adder controller.
interface adder_share_if
    import adder_share_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) ();

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_cin;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_cin;

    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_sum;
    logic               rsp_ca;
    logic               rsp_ovf;
    logic               busy;

    modport master (
        output req_valid, req0_a, req0_b, req0_cin, req1_a, req1_b, req1_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ca, rsp_ovf, busy
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_cin, req1_a, req1_b, req1_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ca, rsp_ovf, busy
    );

endinterface

// File: rtl/adder_share_ctrl_arb.sv
// rr_arb2: two-way one-hot grant. Define ADDER_SHARE_RR_EN for round-robin
// tie breaking; otherwise requester 0 always wins a tie.
module rr_arb2
    import adder_share_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last_id,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_id
);

`ifdef ADDER_SHARE_RR_EN
    localparam arb_mode_e MODE = ARB_RR;
`else
    localparam arb_mode_e MODE = ARB_FIXED;
`endif

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Round-robin hands a tie to whoever did not win last time.
            2'b11:   grant = (MODE == ARB_RR && last_id == 1'b0) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign grant_id = grant[1];

endmodule

// File: rtl/adder_share_ctrl.sv
// Two requesters time-share one combinational adder: IDLE (arbitrate/latch),
// EXEC (add latched operands), RESP (hold result until consumed).
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_share_if.slave bus
);

    state_e             state_reg;
    state_e             state_next;
    logic               last_id_reg;
    logic [WIDTH-1:0]   op_a_reg;
    logic [WIDTH-1:0]   op_b_reg;
    logic               op_cin_reg;
    logic               op_id_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               ca_reg;
    logic               ovf_reg;
    logic               id_reg;

    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic [NUM_REQ-1:0] req_ready;
    logic               accept;
    logic [WIDTH:0]     add_full;
    logic               add_ovf;

    rr_arb2 u_arb (
        .valid    (bus.req_valid),
        .last_id  (last_id_reg),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Gated by rst_n so req_ready is low for the whole reset pulse.
    assign req_ready = (rst_n && state_reg == IDLE) ? grant : 2'b00;
    assign accept    = |(bus.req_valid & req_ready);

    // The single shared adder only ever sees the latched operands.
    assign add_full = {1'b0, op_a_reg} + {1'b0, op_b_reg} + {{WIDTH{1'b0}}, op_cin_reg};
    assign add_ovf  = (op_a_reg[WIDTH-1] == op_b_reg[WIDTH-1]) &&
                      (add_full[WIDTH-1] != op_a_reg[WIDTH-1]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_id_reg <= 1'b1;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            op_cin_reg  <= 1'b0;
            op_id_reg   <= 1'b0;
            sum_reg     <= '0;
            ca_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
            id_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg    <= grant_id ? bus.req1_a   : bus.req0_a;
                op_b_reg    <= grant_id ? bus.req1_b   : bus.req0_b;
                op_cin_reg  <= grant_id ? bus.req1_cin : bus.req0_cin;
                op_id_reg   <= grant_id;
                last_id_reg <= grant_id;
            end
            if (state_reg == EXEC) begin
                sum_reg <= add_full[WIDTH-1:0];
                ca_reg  <= add_full[WIDTH];
                ovf_reg <= add_ovf;
                id_reg  <= op_id_reg;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.rsp_id    = id_reg;
    assign bus.rsp_sum   = sum_reg;
    assign bus.rsp_ca    = ca_reg;
    assign bus.rsp_ovf   = ovf_reg;

endmodule
